// File: rtl/mac_vector_unit.sv
// mac_vector_unit: multi-lane dot-product engine with a two-stage MAC pipeline and a saturated, held result
module mac_vector_unit #(
  parameter int DATA_WIDTH   = 8,
  parameter int LANES        = 4,
  parameter int ACCUM_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 16,
  parameter int SIGNED_MODE  = 1,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          vec_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   input_data,
  input  logic [LANES*DATA_WIDTH-1:0]   weight,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUTPUT_WIDTH-1:0]       result,
  output logic                          overflow,
  output logic                          busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;
  state_t state;
  logic [LEN_WIDTH-1:0] len, cnt;
  logic v1, v2, sticky, accept, carry, ovf, fits;
  logic [ACCUM_WIDTH-1:0] acc, sum, acc_next, hi_s;
  logic [OUTPUT_WIDTH-1:0] sat;
  logic [2*DATA_WIDTH-1:0] prod [LANES];

  function automatic logic [2*DATA_WIDTH-1:0] mul(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] ax, bx;
    ax = SIGNED_MODE != 0 ? {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} : {{DATA_WIDTH{1'b0}}, a};
    bx = SIGNED_MODE != 0 ? {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b} : {{DATA_WIDTH{1'b0}}, b};
    return ax * bx;
  endfunction

  assign accept    = in_valid && in_ready;
  assign in_ready  = state == ACCUM && cnt < len;
  assign out_valid = state == OUTPUT;
  assign busy      = state != IDLE;

  always_ff @(posedge clk)
    if (accept)
      for (int i = 0; i < LANES; i++)
        prod[i] <= mul(input_data[i*DATA_WIDTH +: DATA_WIDTH], weight[i*DATA_WIDTH +: DATA_WIDTH]);

  // fits: accumulator already lies inside the output range, so no clamping is needed
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++)
      sum = sum + (SIGNED_MODE != 0 ? ACCUM_WIDTH'($signed(prod[i])) : ACCUM_WIDTH'(prod[i]));
    {carry, acc_next} = {1'b0, acc} + {1'b0, sum};
    ovf = SIGNED_MODE != 0 ? (acc[ACCUM_WIDTH-1] == sum[ACCUM_WIDTH-1] && acc_next[ACCUM_WIDTH-1] != acc[ACCUM_WIDTH-1]) : carry;
    hi_s = $signed(acc) >>> (OUTPUT_WIDTH-1);
    fits = SIGNED_MODE != 0 ? (hi_s == '0 || &hi_s) : (acc >> OUTPUT_WIDTH) == '0;
    sat = fits ? acc[OUTPUT_WIDTH-1:0] :
          SIGNED_MODE != 0 ? {acc[ACCUM_WIDTH-1], {(OUTPUT_WIDTH-1){~acc[ACCUM_WIDTH-1]}}} : '1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      len      <= '0;
      cnt      <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      acc      <= '0;
      sticky   <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (v1) begin
        acc    <= acc_next;
        sticky <= sticky | ovf;
      end
      if (accept) cnt <= cnt + LEN_WIDTH'(1);
      case (state)
        IDLE: if (start) begin
          len      <= vec_len;
          cnt      <= '0;
          acc      <= '0;
          sticky   <= 1'b0;
          result   <= '0;
          overflow <= 1'b0;
          state    <= vec_len == '0 ? OUTPUT : ACCUM;
        end
        ACCUM: if (accept && cnt + LEN_WIDTH'(1) == len) state <= DRAIN;
        DRAIN: if (!v1 && !v2) begin
          result   <= sat;
          overflow <= sticky | !fits;
          state    <= OUTPUT;
        end
        OUTPUT: if (out_ready) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mac_vector_unit.sv
// tb_mac_vector_unit: signed and unsigned instances driven in lockstep against an integer dot-product model
module tb_mac_vector_unit;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 1;
  logic [7:0] vec_len = '0;
  logic [31:0] input_data = '0, weight = '0;
  logic s_in_ready, s_out_valid, s_overflow, s_busy;
  logic u_in_ready, u_out_valid, u_overflow, u_busy;
  logic [15:0] s_result, u_result;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] a_q[$], w_q[$];
  bit vpat_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_vector_unit u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(s_in_ready), .input_data(input_data), .weight(weight),
    .out_valid(s_out_valid), .out_ready(out_ready), .result(s_result),
    .overflow(s_overflow), .busy(s_busy)
  );

  mac_vector_unit #(.SIGNED_MODE(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(u_in_ready), .input_data(input_data), .weight(weight),
    .out_valid(u_out_valid), .out_ready(out_ready), .result(u_result),
    .overflow(u_overflow), .busy(u_busy)
  );

  task automatic fill(input int n, input logic [7:0] a, input logic [7:0] w);
    a_q.delete();
    w_q.delete();
    for (int b = 0; b < n; b++) begin
      a_q.push_back({4{a}});
      w_q.push_back({4{w}});
    end
  endtask

  // Reference: exact integer dot products, 32-bit wrap per beat, clamp to 16 bits.
  task automatic model(output logic [15:0] rs, output logic os, output logic [15:0] ru, output logic ou);
    longint as_ = 0, au = 0, t, bs, bu;
    logic [7:0] x, y;
    os = 0;
    ou = 0;
    for (int b = 0; b < a_q.size(); b++) begin
      bs = 0;
      bu = 0;
      for (int l = 0; l < 4; l++) begin
        x = a_q[b][8*l +: 8];
        y = w_q[b][8*l +: 8];
        bs += longint'($signed(x)) * longint'($signed(y));
        bu += longint'(x) * longint'(y);
      end
      t = as_ + bs;
      if (t > 64'sd2147483647 || t < -64'sd2147483648) os = 1;
      as_ = longint'(int'(t));
      t = au + bu;
      if (t > 64'sd4294967295) ou = 1;
      au = t & 64'hFFFFFFFF;
    end
    if (as_ > 32767) begin rs = 16'h7FFF; os = 1; end
    else if (as_ < -32768) begin rs = 16'h8000; os = 1; end
    else rs = 16'(as_);
    if (au > 65535) begin ru = 16'hFFFF; ou = 1; end
    else ru = 16'(au);
  endtask

  // Caller must be at a negedge; start is sampled on the next posedge.
  task automatic run_vec(input int n, input int gap, input int hold, input bit has_want, input bit want_u,
                         input logic [15:0] want, input logic want_ovf, input string name);
    logic [15:0] rs, ru;
    logic os, ou, acc;
    int b = 0, g = 0, k = 0, last;
    model(rs, os, ru, ou);
    start = 1;
    vec_len = n[7:0];
    out_ready = hold == 0;
    @(negedge clk);
    start = 0;
    last = cyc;
    while (b < n && g < 2000) begin
      in_valid = vpat_q.size() != 0 ? vpat_q[g % vpat_q.size()] : ($urandom_range(99) >= gap);
      input_data = in_valid ? a_q[b] : $urandom;
      weight = in_valid ? w_q[b] : $urandom;
      acc = in_valid && s_in_ready;
      @(negedge clk);
      if (acc) begin b++; last = cyc; end
      g++;
    end
    in_valid = 0;
    checks++;
    if (b != n) begin errors++; $display("FAIL %s beats: accepted %0d expected %0d", name, b, n); end
    checks++;
    if (s_in_ready !== 1'b0 || u_in_ready !== 1'b0) begin
      errors++; $display("FAIL %s in_ready_drop: got %b/%b expected 0/0", name, s_in_ready, u_in_ready);
    end
    while (!s_out_valid && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (s_out_valid !== 1'b1 || u_out_valid !== 1'b1 || cyc - last != (n == 0 ? 0 : 3)) begin
      errors++; $display("FAIL %s latency: valid %b/%b after %0d cycles expected %0d", name, s_out_valid, u_out_valid, cyc - last, n == 0 ? 0 : 3);
    end
    checks++;
    if (s_result !== rs || s_overflow !== os) begin
      errors++; $display("FAIL %s signed_result: got %h ovf %b expected %h ovf %b", name, s_result, s_overflow, rs, os);
    end
    checks++;
    if (u_result !== ru || u_overflow !== ou) begin
      errors++; $display("FAIL %s unsigned_result: got %h ovf %b expected %h ovf %b", name, u_result, u_overflow, ru, ou);
    end
    if (has_want) begin
      checks++;
      if ((want_u ? u_result : s_result) !== want || (want_u ? u_overflow : s_overflow) !== want_ovf) begin
        errors++; $display("FAIL %s spec_value: got %h ovf %b expected %h ovf %b", name, want_u ? u_result : s_result, want_u ? u_overflow : s_overflow, want, want_ovf);
      end
    end
    for (int h = 0; h < hold; h++) begin
      start = 1;
      vec_len = 8'd3;
      @(negedge clk);
      checks++;
      if (s_out_valid !== 1'b1 || s_busy !== 1'b1 || s_result !== rs || s_overflow !== os) begin
        errors++; $display("FAIL %s hold: valid %b busy %b result %h ovf %b expected 1 1 %h %b", name, s_out_valid, s_busy, s_result, s_overflow, rs, os);
      end
    end
    out_ready = 1;
    start = 1;
    vec_len = 8'd3;
    @(negedge clk);
    start = 0;
    checks++;
    if (s_out_valid !== 1'b0 || s_busy !== 1'b0 || u_busy !== 1'b0) begin
      errors++; $display("FAIL %s release: valid %b busy %b/%b expected 0 0/0", name, s_out_valid, s_busy, u_busy);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({s_in_ready, s_out_valid, s_overflow, s_busy, u_in_ready, u_out_valid, u_overflow, u_busy} !== 8'b0 ||
        s_result !== 16'h0 || u_result !== 16'h0) begin
      errors++;
      $display("FAIL %s outputs: rdy %b/%b vld %b/%b ovf %b/%b busy %b/%b res %h/%h expected all zero", name,
               s_in_ready, u_in_ready, s_out_valid, u_out_valid, s_overflow, u_overflow, s_busy, u_busy, s_result, u_result);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    @(negedge clk);
    check_zero("reset");
    rst_n = 1;
  endtask

  task automatic test_basic;
    fill(2, 8'd3, 8'd5);
    run_vec(2, 0, 0, 1, 0, 16'd120, 1'b0, "basic");
  endtask

  task automatic test_signed_sat;
    fill(1, 8'h80, 8'h7F);
    run_vec(1, 0, 0, 1, 0, 16'h8000, 1'b1, "signed_sat");
  endtask

  task automatic test_gaps;
    fill(3, 8'd1, 8'd1);
    vpat_q = '{1, 0, 0, 1, 0, 1};
    run_vec(3, 0, 0, 1, 0, 16'd12, 1'b0, "gaps");
    vpat_q.delete();
  endtask

  task automatic test_zero_len;
    fill(0, 8'd0, 8'd0);
    run_vec(0, 0, 5, 1, 0, 16'd0, 1'b0, "zero_len");
  endtask

  task automatic test_unsigned_sat;
    fill(1, 8'hFF, 8'hFF);
    run_vec(1, 0, 0, 1, 1, 16'hFFFF, 1'b1, "unsigned_sat");
  endtask

  task automatic test_reset_mid;
    fill(4, 8'd7, 8'd9);
    start = 1;
    vec_len = 8'd4;
    @(negedge clk);
    start = 0;
    in_valid = 1;
    input_data = a_q[0];
    weight = w_q[0];
    @(negedge clk);
    in_valid = 0;
    #2 rst_n = 0;
    #1 check_zero("reset_mid");
    @(negedge clk);
    rst_n = 1;
    fill(1, 8'd2, 8'd2);
    run_vec(1, 0, 0, 1, 0, 16'd16, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back;
    int n;
    for (int v = 0; v < 15; v++) begin
      n = $urandom_range(1, 8);
      a_q.delete();
      w_q.delete();
      for (int b = 0; b < n; b++) begin
        a_q.push_back($urandom_range(3) == 0 ? 32'h80808080 : $urandom);
        w_q.push_back($urandom_range(3) == 0 ? 32'h7F7F7F7F : $urandom);
      end
      run_vec(n, v < 5 ? 0 : $urandom_range(0, 60), $urandom_range(0, 3), 0, 0, 16'h0, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed_sat;
    test_gaps;
    test_zero_len;
    test_unsigned_sat;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
